// File: rtl/dmem_arbiter.sv
// dmem_arbiter - shares the single-port data memory between the core (port 0) and DMA (port 1).
// Core has priority; a starvation counter forces a DMA grant after STARVE_LIMIT lost contests.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_w_en,
  output logic          mem_read_en,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {PRIO_CORE, FORCE_DMA} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          c_err_q, c_err_d;
  logic          d_err_q, d_err_d;

  logic          grant_c, grant_d;
  logic          c_aligned, d_aligned;

  assign c_aligned = (c_addr[1:0] == 2'b00);
  assign d_aligned = (d_addr[1:0] == 2'b00);

  always_comb begin
    grant_c = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (state_q == FORCE_DMA) begin
        grant_d = d_req;
        grant_c = c_req & ~d_req;
      end else begin
        grant_c = c_req;
        grant_d = d_req & ~c_req;
      end
    end
  end

  // Only contested cycles lost by the DMA advance the counter; anything else clears it.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (state_q == PRIO_CORE) begin
      if (c_req && d_req) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
        if (starve_cnt_q >= LIMIT_M1) begin
          state_d = FORCE_DMA;
        end
      end else begin
        starve_cnt_d = '0;
      end
    end else if (grant_d || !d_req) begin
      state_d      = PRIO_CORE;
      starve_cnt_d = '0;
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_w_en    = 1'b0;
    mem_read_en = 1'b0;
    if (grant_c) begin
      mem_addr    = c_addr;
      mem_wdata   = c_wdata;
      mem_w_en    = c_we & c_aligned;
      mem_read_en = ~c_we & c_aligned;
    end else if (grant_d) begin
      mem_addr    = d_addr;
      mem_wdata   = d_wdata;
      mem_w_en    = d_we & d_aligned;
      mem_read_en = ~d_we & d_aligned;
    end
  end

  always_comb begin
    c_rvalid_d = grant_c & ~c_we & c_aligned;
    d_rvalid_d = grant_d & ~d_we & d_aligned;
    c_err_d    = grant_c & ~c_aligned;
    d_err_d    = grant_d & ~d_aligned;
    c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PRIO_CORE;
      starve_cnt_q <= '0;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
      c_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      c_rvalid_q   <= c_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      c_rdata_q    <= c_rdata_d;
      d_rdata_q    <= d_rdata_d;
      c_err_q      <= c_err_d;
      d_err_q      <= d_err_d;
    end
  end

  // Responses are masked while rst is high so a pulse due in the reset cycle never shows.
  assign c_gnt    = grant_c;
  assign d_gnt    = grant_d;
  assign c_rvalid = c_rvalid_q & ~rst;
  assign d_rvalid = d_rvalid_q & ~rst;
  assign c_err    = c_err_q & ~rst;
  assign d_err    = d_err_q & ~rst;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter - directed self-checking bench for dmem_arbiter with a negedge-write memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_w_en, mem_read_en;

  logic [31:0] mem [0:255];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(negedge clk) begin
    if (mem_w_en) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'hCAFEF00D;

    // Reset with both ports requesting
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'h0;
    tick(); tick();
    #2;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_w_en", mem_w_en, 0);
    chk("rst_mem_read_en", mem_read_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);

    // Core write then read-back of the same word
    tick();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    d_req = 1'b0;
    #2;
    chk("wr_c_gnt", c_gnt, 1);
    chk("wr_mem_w_en", mem_w_en, 1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_no_rvalid", c_rvalid, 0);
    c_we = 1'b0;
    #2;
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_mem_read_en", mem_read_en, 1);
    tick();
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);

    // Continuous contest: C,C,C,C,D repeating
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h2;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("starve_d_gnt_%0d", i), d_gnt, (i % 5 == 4) ? 1 : 0);
      chk($sformatf("starve_c_gnt_%0d", i), c_gnt, (i % 5 == 4) ? 0 : 1);
      tick();
    end

    // DMA read alone
    c_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    #2;
    chk("dma_d_gnt", d_gnt, 1);
    chk("dma_c_gnt", c_gnt, 0);
    chk("dma_mem_read_en", mem_read_en, 1);
    tick();
    chk("dma_d_rvalid", d_rvalid, 1);
    chk("dma_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("dma_c_rvalid", c_rvalid, 0);

    // Misaligned core write
    d_req = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h13; c_wdata = 32'h11111111;
    #2;
    chk("mis_c_gnt", c_gnt, 1);
    chk("mis_mem_w_en", mem_w_en, 0);
    tick();
    chk("mis_c_err", c_err, 1);
    chk("mis_c_rvalid", c_rvalid, 0);
    chk("mis_mem_unchanged", mem[4], 32'hDEADBEEF);
    chk("dma_rvalid_pulse", d_rvalid, 0);
    c_req = 1'b0;
    #2;
    tick();
    chk("mis_c_err_pulse", c_err, 0);

    // Reset after a granted read, with the FSM in FORCE_DMA
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("pre_rst_c_gnt_%0d", i), c_gnt, 1);
      tick();
    end
    rst = 1'b1;
    #2;
    chk("midrst_c_rvalid", c_rvalid, 0);
    chk("midrst_c_gnt", c_gnt, 0);
    chk("midrst_d_gnt", d_gnt, 0);
    tick();
    rst = 1'b0;
    #2;
    chk("postrst_c_gnt", c_gnt, 1);
    chk("postrst_d_gnt", d_gnt, 0);
    tick();
    chk("postrst_c_rvalid", c_rvalid, 1);
    chk("postrst_c_rdata", c_rdata, 32'hDEADBEEF);
    c_req = 1'b0; d_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
